fb_write_scheduler: RTL and testbench

//  Owns the 512x342 frame-buffer write port in the input pixel domain. Shares it between
//  the scaler stream and the test-pattern generator, so no write-clock mux is needed.

---
 rtl/fb_write_scheduler.sv | 161 ++++++++++++++++
 tb/tb_fb_write_scheduler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_scheduler.sv
// Frame-buffer write-port owner: clears the buffer, then forwards writes from the scaler or
// the test-pattern source, switching source only at start of frame.
//   state         | meaning
//   ST_CLEAR      | writing CLEAR_VALUE to every address, inputs ignored
//   ST_WAIT_SOF   | buffer clean, waiting for sof to pick the source
//   ST_RUN_SCALER | scaler owns the write port
//   ST_RUN_TEST   | test-pattern generator owns the write port
module fb_write_scheduler #(
  parameter int   ADDR_WIDTH  = 18,
  parameter int   DEPTH       = 175104,
  parameter logic CLEAR_VALUE = 1'b1,
  parameter int   SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  test_mode_async,
  input  logic                  sof,
  input  logic                  s_valid,
  input  logic [ADDR_WIDTH-1:0] s_addr,
  input  logic                  s_data,
  output logic                  s_ready,
  input  logic                  t_valid,
  input  logic [ADDR_WIDTH-1:0] t_addr,
  input  logic                  t_data,
  output logic                  t_ready,
  output logic                  fb_we,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  output logic                  fb_wdata,
  output logic [1:0]            active_src,
  output logic                  clear_busy,
  output logic                  addr_err,
  output logic [ADDR_WIDTH:0]   frame_wr_count
);

  typedef enum logic [1:0] {
    ST_CLEAR      = 2'd0,
    ST_WAIT_SOF   = 2'd1,
    ST_RUN_SCALER = 2'd2,
    ST_RUN_TEST   = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] CLR_LAST  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                  state, state_next;
  logic [SYNC_STAGES-1:0]  mode_sync;
  logic                    mode;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [ADDR_WIDTH:0]     wr_cnt;
  logic                    sel_valid;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic                    sel_data;
  logic                    in_range;
  logic                    commit;
  logic [ADDR_WIDTH:0]     commit_ext;

  assign mode = mode_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_sync <= '0;
    end else begin
      mode_sync <= {mode_sync[SYNC_STAGES-2:0], test_mode_async};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_CLEAR;
    end else begin
      state <= state_next;
    end
  end

  // A mode change is only acted on at sof; a toggle that reverts before sof is invisible.
  always_comb begin
    state_next = state;
    case (state)
      ST_CLEAR:      if (clr_cnt == CLR_LAST) state_next = ST_WAIT_SOF;
      ST_WAIT_SOF:   if (sof) state_next = mode ? ST_RUN_TEST : ST_RUN_SCALER;
      ST_RUN_SCALER: if (sof && mode) state_next = ST_CLEAR;
      ST_RUN_TEST:   if (sof && !mode) state_next = ST_CLEAR;
      default:       state_next = ST_CLEAR;
    endcase
  end

  // Ready is a pure state decode, so a presented valid in a RUN state is a handshake.
  always_comb begin
    sel_valid = 1'b0;
    sel_addr  = '0;
    sel_data  = 1'b0;
    case (state)
      ST_RUN_SCALER: begin
        sel_valid = s_valid;
        sel_addr  = s_addr;
        sel_data  = s_data;
      end
      ST_RUN_TEST: begin
        sel_valid = t_valid;
        sel_addr  = t_addr;
        sel_data  = t_data;
      end
      default: begin
        sel_valid = 1'b0;
      end
    endcase
  end

  assign in_range   = ({1'b0, sel_addr} < DEPTH_EXT);
  assign commit     = sel_valid & in_range;
  assign commit_ext = {{ADDR_WIDTH{1'b0}}, commit};

  assign s_ready    = (state == ST_RUN_SCALER);
  assign t_ready    = (state == ST_RUN_TEST);
  assign active_src = {state == ST_RUN_TEST, state == ST_RUN_SCALER};
  assign clear_busy = (state == ST_CLEAR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fb_we          <= 1'b0;
      fb_addr        <= '0;
      fb_wdata       <= 1'b0;
      clr_cnt        <= '0;
      wr_cnt         <= '0;
      addr_err       <= 1'b0;
      frame_wr_count <= '0;
    end else begin
      fb_we <= 1'b0;
      case (state)
        ST_CLEAR: begin
          fb_we    <= 1'b1;
          fb_addr  <= clr_cnt;
          fb_wdata <= CLEAR_VALUE;
          clr_cnt  <= (clr_cnt == CLR_LAST) ? '0 : clr_cnt + 1'b1;
          wr_cnt   <= '0;
        end
        ST_WAIT_SOF: begin
          clr_cnt <= '0;
          wr_cnt  <= '0;
        end
        default: begin
          clr_cnt <= '0;
          if (commit) begin
            fb_we    <= 1'b1;
            fb_addr  <= sel_addr;
            fb_wdata <= sel_data;
          end
          if (sel_valid && !in_range) addr_err <= 1'b1;
          // A write accepted alongside sof belongs to the closing frame's total and opens the next.
          if (sof) begin
            frame_wr_count <= wr_cnt + commit_ext;
            wr_cnt         <= commit_ext;
          end else begin
            wr_cnt <= wr_cnt + commit_ext;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Directed bench for fb_write_scheduler, built with a small buffer so each clear is short.
module tb_fb_write_scheduler;

  localparam int AW    = 18;
  localparam int DEPTH = 64;

  logic          clk;
  logic          reset;
  logic          test_mode_async;
  logic          sof;
  logic          s_valid;
  logic [AW-1:0] s_addr;
  logic          s_data;
  logic          s_ready;
  logic          t_valid;
  logic [AW-1:0] t_addr;
  logic          t_data;
  logic          t_ready;
  logic          fb_we;
  logic [AW-1:0] fb_addr;
  logic          fb_wdata;
  logic [1:0]    active_src;
  logic          clear_busy;
  logic          addr_err;
  logic [AW:0]   frame_wr_count;

  int errors = 0;
  int checks = 0;

  fb_write_scheduler #(
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .CLEAR_VALUE(1'b1),
    .SYNC_STAGES(2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .test_mode_async(test_mode_async),
    .sof            (sof),
    .s_valid        (s_valid),
    .s_addr         (s_addr),
    .s_data         (s_data),
    .s_ready        (s_ready),
    .t_valid        (t_valid),
    .t_addr         (t_addr),
    .t_data         (t_data),
    .t_ready        (t_ready),
    .fb_we          (fb_we),
    .fb_addr        (fb_addr),
    .fb_wdata       (fb_wdata),
    .active_src     (active_src),
    .clear_busy     (clear_busy),
    .addr_err       (addr_err),
    .frame_wr_count (frame_wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs through one clear pass and checks count, address order and data.
  task automatic clear_pass(input string tag);
    int n;
    int bad;
    n   = 0;
    bad = 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      tick();
      if (i == 0) check({tag, "_busy"}, 32'(clear_busy), 32'd1);
      if (fb_we === 1'b1) begin
        if (fb_addr !== AW'(n) || fb_wdata !== 1'b1) bad++;
        n++;
      end
    end
    check({tag, "_cnt"}, 32'(n), 32'(DEPTH));
    check({tag, "_seq"}, 32'(bad), 32'd0);
    check({tag, "_done"}, 32'(clear_busy), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    test_mode_async = 1'b0;
    sof = 1'b0;
    s_valid = 1'b0; s_addr = '0; s_data = 1'b0;
    t_valid = 1'b0; t_addr = '0; t_data = 1'b0;

    tick(); tick();
    check("rst_we", 32'(fb_we), 32'd0);
    check("rst_addr", 32'(fb_addr), 32'd0);
    check("rst_wdata", 32'(fb_wdata), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_t_ready", 32'(t_ready), 32'd0);
    check("rst_src", 32'(active_src), 32'd0);
    check("rst_busy", 32'(clear_busy), 32'd1);
    check("rst_err", 32'(addr_err), 32'd0);
    check("rst_count", 32'(frame_wr_count), 32'd0);

    reset = 1'b1;
    clear_pass("clr0");
    check("wait_s_ready", 32'(s_ready), 32'd0);
    check("wait_src", 32'(active_src), 32'd0);

    sof = 1'b1; tick(); sof = 1'b0;
    check("run_s_ready", 32'(s_ready), 32'd1);
    check("run_t_ready", 32'(t_ready), 32'd0);
    check("run_src", 32'(active_src), 32'd1);

    s_valid = 1'b1; s_addr = AW'(5); s_data = 1'b0;
    tick(); s_valid = 1'b0;
    check("wr5_we", 32'(fb_we), 32'd1);
    check("wr5_addr", 32'(fb_addr), 32'd5);
    check("wr5_data", 32'(fb_wdata), 32'd0);
    tick();
    check("idle_we", 32'(fb_we), 32'd0);

    s_valid = 1'b1; s_addr = AW'(DEPTH); s_data = 1'b1;
    tick(); s_valid = 1'b0;
    check("oor_we", 32'(fb_we), 32'd0);
    check("oor_err", 32'(addr_err), 32'd1);

    sof = 1'b1; tick(); sof = 1'b0;
    check("frame1_count", 32'(frame_wr_count), 32'd1);
    check("frame1_src", 32'(active_src), 32'd1);

    for (int i = 0; i < 1000; i++) begin
      s_valid = 1'b1; s_addr = AW'(i % DEPTH); s_data = i[0];
      tick();
    end
    check("w999_addr", 32'(fb_addr), 32'd39);
    check("w999_data", 32'(fb_wdata), 32'd1);
    s_addr = AW'(7); s_data = 1'b1; sof = 1'b1;
    tick(); sof = 1'b0; s_valid = 1'b0;
    check("frame2_count", 32'(frame_wr_count), 32'd1001);
    check("sofwr_we", 32'(fb_we), 32'd1);
    check("sofwr_addr", 32'(fb_addr), 32'd7);

    test_mode_async = 1'b1;
    tick(); tick(); tick();
    s_valid = 1'b1; s_addr = AW'(9); s_data = 1'b0;
    t_valid = 1'b1; t_addr = AW'(3); t_data = 1'b1;
    tick();
    check("mid_s_ready", 32'(s_ready), 32'd1);
    check("mid_t_ready", 32'(t_ready), 32'd0);
    check("mid_addr", 32'(fb_addr), 32'd9);
    s_addr = AW'(10); s_data = 1'b1; sof = 1'b1;
    tick(); sof = 1'b0; s_valid = 1'b0; t_valid = 1'b0;
    check("sw_we", 32'(fb_we), 32'd1);
    check("sw_addr", 32'(fb_addr), 32'd10);
    check("sw_count", 32'(frame_wr_count), 32'd3);
    check("sw_s_ready", 32'(s_ready), 32'd0);
    check("sw_busy", 32'(clear_busy), 32'd1);

    clear_pass("clr1");
    check("clr1_err", 32'(addr_err), 32'd1);
    check("clr1_t_ready", 32'(t_ready), 32'd0);

    sof = 1'b1; tick(); sof = 1'b0;
    check("test_t_ready", 32'(t_ready), 32'd1);
    check("test_s_ready", 32'(s_ready), 32'd0);
    check("test_src", 32'(active_src), 32'd2);
    t_valid = 1'b1; t_addr = AW'(12); t_data = 1'b0;
    tick(); t_valid = 1'b0;
    check("t12_we", 32'(fb_we), 32'd1);
    check("t12_addr", 32'(fb_addr), 32'd12);

    test_mode_async = 1'b0;
    tick(); tick(); tick();
    test_mode_async = 1'b1;
    tick(); tick(); tick();
    sof = 1'b1; tick(); sof = 1'b0;
    check("glitch_t_ready", 32'(t_ready), 32'd1);
    check("glitch_busy", 32'(clear_busy), 32'd0);
    check("glitch_count", 32'(frame_wr_count), 32'd1);

    t_valid = 1'b1; t_addr = AW'(20); t_data = 1'b1;
    tick(); t_valid = 1'b0;
    check("pre_rst_we", 32'(fb_we), 32'd1);
    reset = 1'b0;
    #2;
    check("arst_we", 32'(fb_we), 32'd0);
    check("arst_addr", 32'(fb_addr), 32'd0);
    check("arst_t_ready", 32'(t_ready), 32'd0);
    check("arst_src", 32'(active_src), 32'd0);
    check("arst_busy", 32'(clear_busy), 32'd1);
    check("arst_err", 32'(addr_err), 32'd0);
    check("arst_count", 32'(frame_wr_count), 32'd0);

    tick();
    reset = 1'b1;
    tick();
    check("rclr_we", 32'(fb_we), 32'd1);
    check("rclr_addr", 32'(fb_addr), 32'd0);
    tick();
    check("rclr_addr1", 32'(fb_addr), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
